// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer feeding the 20-bit instruction input of simple_cpu.
// A small loadable program store is walked by a program counter. Each fetched
// word is held on instruction_o for ISSUE_CYCLES clocks so the multi-cycle
// control unit can complete it. Supports free-run and single-step execution,
// a HALT word that ends the program, and abort back to IDLE.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   load_en_i      write load_data_i into the store at load_addr_i
//                  (honoured only in IDLE or HALTED)
//   load_addr_i    program store write address
//   load_data_i    program store write data
//   start_i        begin execution at pc=0 (IDLE/HALTED only)
//   step_mode_i    1: pause in WAIT_STEP after each instruction
//   step_i         advance one instruction while in WAIT_STEP
//   abort_i        return to IDLE from FETCH/ISSUE/WAIT_STEP
//   instruction_o  word presented to simple_cpu.instruction
//   instr_valid_o  instruction_o carries a real program word
//   pc_o           address of the current/next instruction
//   busy_o         1 in FETCH, ISSUE or WAIT_STEP
//   done_o         1 in HALTED
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int                     INSTR_WIDTH  = 20,
    parameter int                     PC_BITS      = 4,
    parameter int                     ISSUE_CYCLES = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR    = 20'h00000,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR   = 20'hFFFFF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_en_i,
    input  logic [PC_BITS-1:0]     load_addr_i,
    input  logic [INSTR_WIDTH-1:0] load_data_i,
    input  logic                   start_i,
    input  logic                   step_mode_i,
    input  logic                   step_i,
    input  logic                   abort_i,
    output logic [INSTR_WIDTH-1:0] instruction_o,
    output logic                   instr_valid_o,
    output logic [PC_BITS-1:0]     pc_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int DEPTH = 2 ** PC_BITS;
    // Counter must be at least one bit wide even when ISSUE_CYCLES is 1.
    localparam int CNT_W = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ISSUE_CYCLES - 1);
    localparam logic [PC_BITS-1:0] PC_LAST  = {PC_BITS{1'b1}};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_STEP = 3'd3;
    localparam logic [2:0] ST_HALTED    = 3'd4;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic [2:0]             state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [INSTR_WIDTH-1:0] fetch_word_s;
    logic                   last_issue_s;
    logic                   mem_we_s;

    assign fetch_word_s = mem_q[pc_q];
    assign last_issue_s = (cnt_q == CNT_LAST);
    // Host writes are only allowed while the program is not running.
    assign mem_we_s     = load_en_i && ((state_q == ST_IDLE) || (state_q == ST_HALTED));

    // Program store: no reset, so a program survives rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    // Next-state, PC and issue-counter logic; outputs are decoded from the
    // next state so they can be registered without an extra cycle of lag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = {PC_BITS{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (fetch_word_s == HALT_INSTR) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_ISSUE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (last_issue_s) begin
                    // Last address halts rather than wrapping back to 0.
                    if (pc_q == PC_LAST) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = pc_q + PC_BITS'(1);
                        state_d = step_mode_i ? ST_WAIT_STEP : ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_STEP: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (step_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WAIT_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_ISSUE);
        busy_d  = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_WAIT_STEP);
        done_d  = (state_d == ST_HALTED);

        // The issued word is captured on the FETCH->ISSUE edge and held
        // unchanged for the whole issue window; NOP everywhere else.
        if (state_d == ST_ISSUE) begin
            if (state_q == ST_FETCH) begin
                instr_d = fetch_word_s;
            end else begin
                instr_d = instr_q;
            end
        end else begin
            instr_d = NOP_INSTR;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= {PC_BITS{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction_o = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. The stimulus process pushes each
// expected issue (word and hold length) into a queue before starting a run;
// a negedge monitor pops an entry whenever instr_valid rises and checks the
// word on every valid clock and the hold length when valid drops.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam logic [19:0] NOP  = 20'h00000;
    localparam logic [19:0] HALT = 20'hFFFFF;
    localparam logic [19:0] WA   = 20'h12345;
    localparam logic [19:0] WB   = 20'h2ABCD;
    localparam logic [19:0] WC   = 20'h3C0DE;
    localparam logic [19:0] WD   = 20'h4D00D;
    localparam logic [19:0] WE   = 20'h5EEEE;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [19:0] load_data;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        abort;
    logic [19:0] instruction;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    typedef struct {
        logic [19:0] data;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;
    int   run_len = 0;

    instr_sequencer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .load_en_i     (load_en),
        .load_addr_i   (load_addr),
        .load_data_i   (load_data),
        .start_i       (start),
        .step_mode_i   (step_mode),
        .step_i        (step),
        .abort_i       (abort),
        .instruction_o (instruction),
        .instr_valid_o (instr_valid),
        .pc_o          (pc),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [19:0] d, input int len);
        exp_t e;
        e.data = d;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [3:0] a, input logic [19:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk);
        #1;
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_word(input string name, input logic [19:0] w, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_valid && instruction == w) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    {28'd0, pc}, 32'd0);
        chk({tag, "_instr"}, {12'd0, instruction}, {12'd0, NOP});
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
        chk({tag, "_done"},  {31'd0, done}, 32'd0);
    endtask

    task automatic load_abc();
        load(4'd0, WA);
        load(4'd1, WB);
        load(4'd2, WC);
        load(4'd3, HALT);
    endtask

    // Monitor: pops one expectation per issue and checks word and hold length.
    always @(negedge clk) begin
        if (instr_valid) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", {12'd0, instruction}, {12'd0, NOP});
                    cur.data = instruction;
                    cur.len  = 0;
                end else begin
                    cur = exp_q.pop_front();
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            chk("issue_word", {12'd0, instruction}, {12'd0, cur.data});
        end else begin
            chk("nop_when_idle", {12'd0, instruction}, {12'd0, NOP});
            if (prev_valid) begin
                chk("hold_len", run_len, cur.len);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_data = 20'd0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // 1: free run A,B,C then HALT
        load_abc();
        push(WA, 3); push(WB, 3); push(WC, 3);
        pulse_start();
        @(negedge clk);
        chk("t1_fetch_valid", {31'd0, instr_valid}, 32'd0);
        chk("t1_fetch_busy",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_latency_valid", {31'd0, instr_valid}, 32'd1);
        wait_done("t1_done", 60);
        chk("t1_pc",    {28'd0, pc}, 32'd3);
        chk("t1_busy",  {31'd0, busy}, 32'd0);
        chk("t1_valid", {31'd0, instr_valid}, 32'd0);

        // 2: single step
        step_mode = 1'b1;
        push(WA, 3); push(WB, 3); push(WC, 3);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t2_wait_valid", {31'd0, instr_valid}, 32'd0);
        chk("t2_wait_busy",  {31'd0, busy}, 32'd1);
        chk("t2_wait_pc",    {28'd0, pc}, 32'd1);
        chk("t2_wait_done",  {31'd0, done}, 32'd0);
        pulse_step();
        @(negedge clk);
        chk("t2_step_fetch", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("t2_step_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_step_word",  {12'd0, instruction}, {12'd0, WB});
        repeat (10) @(negedge clk);
        chk("t2_wait2_pc", {28'd0, pc}, 32'd2);
        pulse_step();
        repeat (10) @(negedge clk);
        pulse_step();
        wait_done("t2_done", 10);
        chk("t2_pc", {28'd0, pc}, 32'd3);
        step_mode = 1'b0;

        // 3: full store, no wrap
        for (int i = 0; i < 16; i++) begin
            load(4'(i), 20'h10000 + 20'(i));
            push(20'h10000 + 20'(i), 3);
        end
        pulse_start();
        wait_done("t3_done", 200);
        chk("t3_pc", {28'd0, pc}, 32'd15);
        repeat (5) @(negedge clk);
        chk("t3_pc_hold",   {28'd0, pc}, 32'd15);
        chk("t3_done_hold", {31'd0, done}, 32'd1);
        chk("t3_busy",      {31'd0, busy}, 32'd0);

        // 4: abort on the 2nd issue clock of B
        load_abc();
        push(WA, 3); push(WB, 2);
        pulse_start();
        wait_word("t4_see_b", WB, 40);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_instr", {12'd0, instruction}, {12'd0, NOP});
        chk("t4_busy",  {31'd0, busy}, 32'd0);
        chk("t4_done",  {31'd0, done}, 32'd0);
        chk("t4_pc",    {28'd0, pc}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        push(WA, 3); push(WB, 3); push(WC, 3);
        pulse_start();
        wait_done("t4_done", 60);
        chk("t4_pc_end", {28'd0, pc}, 32'd3);

        // 5: reset mid-issue, store survives
        push(WA, 2);
        pulse_start();
        wait_word("t5_see_a", WA, 20);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("t5_rst");
        push(WA, 3); push(WB, 3); push(WC, 3);
        pulse_start();
        wait_done("t5_done", 60);
        chk("t5_pc", {28'd0, pc}, 32'd3);

        // 6: load while busy ignored; load+start together in IDLE
        push(WA, 3); push(WB, 3); push(WC, 3);
        pulse_start();
        wait_word("t6_see_a", WA, 20);
        load_en = 1'b1; load_addr = 4'd1; load_data = WD;
        repeat (6) tick();
        load_en = 1'b0;
        wait_done("t6_done", 60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(WE, 3); push(WB, 3); push(WC, 3);
        load_en = 1'b1; load_addr = 4'd0; load_data = WE; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        wait_done("t6_done2", 60);
        chk("t6_pc", {28'd0, pc}, 32'd3);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
